// File: rtl/jtopl_eg_rate.sv
// rtl/jtopl_eg_rate.sv - envelope rate/step engine: slot sequencer, global counter, per-slot step decision
module jtopl_eg_rate #(
    parameter int NSLOTS = 18,
    parameter int CNTW   = 15,
    parameter int SLOTW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cen,
    input  logic             i_attack,
    input  logic [4:0]       i_base_rate,
    input  logic [3:0]       i_keycode,
    input  logic             i_ksr,
    input  logic             i_kon,
    output logic [SLOTW-1:0] o_slot,
    output logic [CNTW-1:0]  o_eg_cnt,
    output logic             o_step,
    output logic [5:0]       o_rate,
    output logic             o_sum_up,
    output logic [SLOTW-1:0] o_out_slot,
    output logic             o_out_valid
);
    localparam int TOPSEL = CNTW - 4;

    logic [SLOTW-1:0]      r_slot;
    logic [CNTW-1:0]       r_eg_cnt;
    logic                  r_step;
    logic [5:0]            r_rate;
    logic                  r_sum_up;
    logic [SLOTW-1:0]      r_out_slot;
    logic                  r_out_valid;
    logic [2**SLOTW-1:0]   r_lsb;

    logic [3:0] w_ks;
    logic [6:0] w_pre;
    logic [5:0] w_rate;
    logic [4:0] w_sel;
    int         w_shamt;
    logic [2:0] w_cnt;
    logic [7:0] w_pat;
    logic       w_step;
    logic       w_prev;
    logic       w_last;

    assign w_ks   = i_ksr ? (i_keycode >> 1) : (i_keycode >> 3);
    assign w_pre  = (i_base_rate == 5'd0) ? 7'd0
                  : ({1'b0, i_base_rate, 1'b0} + {3'b000, w_ks});
    assign w_rate = (w_pre >= 7'd60) ? 6'd63 : w_pre[5:0];
    assign w_sel  = i_attack ? ({1'b0, w_rate[5:2]} + 5'd1) : {1'b0, w_rate[5:2]};

    // Faster rates tap lower (faster toggling) counter bits; saturate at the bottom 3 bits.
    always_comb begin
        w_shamt = 0;
        if (int'(w_sel) < TOPSEL)
            w_shamt = TOPSEL - int'(w_sel);
    end

    assign w_cnt = 3'(r_eg_cnt >> w_shamt);

    always_comb begin
        w_pat = 8'h00;
        if (w_rate[5:4] == 2'b11) begin
            if (i_attack && (w_rate[5:2] == 4'hF)) begin
                w_pat = 8'hFF;
            end else begin
                case (w_rate[1:0])
                    2'd0:    w_pat = 8'h00;
                    2'd1:    w_pat = 8'h88;
                    2'd2:    w_pat = 8'hAA;
                    default: w_pat = 8'hEE;
                endcase
            end
        end else begin
            if (!i_attack && (w_rate[5:2] == 4'h0)) begin
                w_pat = 8'hFE;
            end else begin
                case (w_rate[1:0])
                    2'd0:    w_pat = 8'hAA;
                    2'd1:    w_pat = 8'hEA;
                    2'd2:    w_pat = 8'hEE;
                    default: w_pat = 8'hFE;
                endcase
            end
        end
    end

    assign w_step = (w_rate[5:1] == 5'd0) ? 1'b0 : w_pat[w_cnt];
    assign w_prev = i_kon ? 1'b0 : r_lsb[r_slot];
    assign w_last = (r_slot == SLOTW'(NSLOTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot      <= '0;
            r_eg_cnt    <= '0;
            r_step      <= 1'b0;
            r_rate      <= 6'd0;
            r_sum_up    <= 1'b0;
            r_out_slot  <= '0;
            r_out_valid <= 1'b0;
            r_lsb       <= '0;
        end else begin
            r_out_valid <= i_cen;
            if (i_cen) begin
                r_slot        <= w_last ? '0 : (r_slot + SLOTW'(1));
                if (w_last)
                    r_eg_cnt  <= r_eg_cnt + CNTW'(1);
                r_step        <= w_step;
                r_rate        <= w_rate;
                r_sum_up      <= w_cnt[0] != w_prev;
                r_out_slot    <= r_slot;
                r_lsb[r_slot] <= w_cnt[0];
            end
        end
    end

    assign o_slot      = r_slot;
    assign o_eg_cnt    = r_eg_cnt;
    assign o_step      = r_step;
    assign o_rate      = r_rate;
    assign o_sum_up    = r_sum_up;
    assign o_out_slot  = r_out_slot;
    assign o_out_valid = r_out_valid;
endmodule

// File: tb/tb_jtopl_eg_rate.sv
// tb/tb_jtopl_eg_rate.sv - directed self-checking bench for jtopl_eg_rate
module tb_jtopl_eg_rate;
    localparam int NSLOTS = 18;
    localparam int CNTW   = 8;
    localparam int SLOTW  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cen = 1'b0;
    logic             attack = 1'b0;
    logic [4:0]       br = 5'd0;
    logic [3:0]       kc = 4'd0;
    logic             ksr = 1'b0;
    logic             kon = 1'b0;
    logic [SLOTW-1:0] o_slot;
    logic [CNTW-1:0]  o_eg_cnt;
    logic             o_step;
    logic [5:0]       o_rate;
    logic             o_sum_up;
    logic [SLOTW-1:0] o_out_slot;
    logic             o_out_valid;

    int checks = 0;
    int errors = 0;
    int exp_slot = 0;
    int exp_eg = 0;

    jtopl_eg_rate #(.NSLOTS(NSLOTS), .CNTW(CNTW), .SLOTW(SLOTW)) dut (
        .clk(clk), .rst_n(rst_n), .i_cen(cen), .i_attack(attack),
        .i_base_rate(br), .i_keycode(kc), .i_ksr(ksr), .i_kon(kon),
        .o_slot(o_slot), .o_eg_cnt(o_eg_cnt), .o_step(o_step), .o_rate(o_rate),
        .o_sum_up(o_sum_up), .o_out_slot(o_out_slot), .o_out_valid(o_out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c);
        cen = c;
        @(posedge clk);
        #1;
        if (c) begin
            if (exp_slot == NSLOTS - 1) begin
                exp_slot = 0;
                exp_eg   = (exp_eg + 1) % (1 << CNTW);
            end else begin
                exp_slot++;
            end
        end
    endtask

    task automatic set_in(input logic a, input logic [4:0] b, input logic [3:0] k,
                          input logic s, input logic n);
        attack = a; br = b; kc = k; ksr = s; kon = n;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slot", o_slot, 0);
        chk("rst_eg", o_eg_cnt, 0);
        chk("rst_step", o_step, 0);
        chk("rst_rate", o_rate, 0);
        chk("rst_sum", o_sum_up, 0);
        chk("rst_oslot", o_out_slot, 0);
        chk("rst_valid", o_out_valid, 0);
        @(negedge clk) rst_n = 1'b1;

        // reset in the middle of a revolution
        repeat (7) cyc(1'b1);
        chk("run_slot7", o_slot, 7);
        chk("run_oslot6", o_out_slot, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_slot", o_slot, 0);
        chk("mid_rst_oslot", o_out_slot, 0);
        chk("mid_rst_valid", o_out_valid, 0);
        chk("mid_rst_eg", o_eg_cnt, 0);
        exp_slot = 0;
        exp_eg   = 0;
        #1 rst_n = 1'b1;
        cyc(1'b1);
        chk("post_rst_oslot", o_out_slot, 0);
        chk("post_rst_valid", o_out_valid, 1);
        chk("post_rst_slot", o_slot, 1);

        // one full revolution, then a cen stall
        repeat (17) cyc(1'b1);
        chk("wrap_slot", o_slot, 0);
        chk("wrap_eg", o_eg_cnt, 1);
        repeat (10) cyc(1'b0);
        chk("stall_slot", o_slot, 0);
        chk("stall_eg", o_eg_cnt, 1);
        chk("stall_valid", o_out_valid, 0);
        chk("stall_oslot", o_out_slot, 17);

        // rate calculation
        set_in(1'b0, 5'd10, 4'd9, 1'b1, 1'b0); cyc(1'b1);
        chk("rate_ksr1", o_rate, 24);
        chk("rate_ksr1_oslot", o_out_slot, 0);
        set_in(1'b0, 5'd10, 4'd9, 1'b0, 1'b0); cyc(1'b1);
        chk("rate_ksr0", o_rate, 21);
        set_in(1'b0, 5'd31, 4'd9, 1'b0, 1'b0); cyc(1'b1);
        chk("rate_br31", o_rate, 63);
        set_in(1'b0, 5'd30, 4'd0, 1'b0, 1'b0); cyc(1'b1);
        chk("rate_pre60", o_rate, 63);
        set_in(1'b0, 5'd29, 4'd2, 1'b0, 1'b0); cyc(1'b1);
        chk("rate_pre58", o_rate, 58);
        set_in(1'b0, 5'd29, 4'd15, 1'b1, 1'b0); cyc(1'b1);
        chk("rate_pre65", o_rate, 63);
        set_in(1'b0, 5'd0, 4'd15, 1'b1, 1'b0); cyc(1'b1);
        chk("rate_br0", o_rate, 0);

        // fresh start for the per-slot memory tests
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_slot = 0;
        exp_eg   = 0;

        // rate 0x10 taps eg_cnt[2:0]; its LSB toggles every revolution
        set_in(1'b0, 5'd8, 4'd0, 1'b0, 1'b0);
        cyc(1'b1);
        chk("r0_rate", o_rate, 16);
        chk("r0_sum", o_sum_up, 0);
        chk("r0_step", o_step, 0);
        repeat (17) cyc(1'b1);
        cyc(1'b1);
        chk("r1_step", o_step, 1);
        chk("r1_sum", o_sum_up, 1);
        for (int i = 1; i < NSLOTS; i++) begin
            cyc(1'b1);
            chk("r1_sum_toggle", o_sum_up, 1);
        end

        // rate 12 taps eg_cnt[3:1]; LSB (eg_cnt[1]) stays 1 for eg_cnt 2 and 3
        set_in(1'b0, 5'd6, 4'd0, 1'b0, 1'b0);
        cyc(1'b1);
        chk("r2_rate", o_rate, 12);
        chk("r2_sum_steady", o_sum_up, 0);
        chk("r2_step", o_step, 1);
        repeat (17) cyc(1'b1);
        cyc(1'b1);
        chk("r3_sum_steady", o_sum_up, 0);
        kon = 1'b1;
        cyc(1'b1);
        chk("r3_kon_sum", o_sum_up, 1);
        chk("r3_kon_oslot", o_out_slot, 1);
        kon = 1'b0;
        repeat (16) cyc(1'b1);
        chk("r4_eg", o_eg_cnt, 4);

        // step patterns at eg_cnt=4
        set_in(1'b1, 5'd31, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            chk("att63_step", o_step, 1);
        end
        chk("att63_rate", o_rate, 63);
        set_in(1'b1, 5'd0, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk("br0_step", o_step, 0);
        end
        set_in(1'b0, 5'd31, 4'd0, 1'b0, 1'b0);
        cyc(1'b1);
        chk("dec63_step", o_step, 0);

        // run up to the all-ones counter wrap
        set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            if (exp_slot == NSLOTS - 1 && exp_eg == (1 << CNTW) - 1) break;
            cyc(1'b1);
        end
        chk("pre_wrap_eg", o_eg_cnt, (1 << CNTW) - 1);
        chk("pre_wrap_slot", o_slot, NSLOTS - 1);
        set_in(1'b0, 5'd8, 4'd0, 1'b0, 1'b0);
        cyc(1'b1);
        chk("wrap_step_pre_inc", o_step, 1);
        chk("wrap_eg_zero", o_eg_cnt, 0);
        chk("wrap_slot_zero", o_slot, 0);
        chk("wrap_oslot", o_out_slot, NSLOTS - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
